// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit: funct3 access sizes,
// writeback select codes, the LSU state type and the misalignment rule.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WB_SEL_DMEM = 2'b00;
  localparam logic [1:0] WB_SEL_ALU  = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_t;

  // Halfwords need an even address and words a 4-byte aligned one; bytes never trap.
  function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] addrLo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_H, F3_HU: mis = addrLo[0];
      F3_W:        mis = (addrLo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Picks the addressed byte/halfword lane out of a memory read word and
// sign- or zero-extends it according to the load funct3.
module lsu_load_format
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addrLo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] loadData_o
);

  logic [15:0] lane;

  // Shift the addressed byte down to bit 0, then extend by access size and signedness.
  always_comb begin
    lane = 16'(rdata_i >> {addrLo_i, 3'b000});
    case (funct3_i)
      F3_B:    loadData_o = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   loadData_o = {24'b0, lane[7:0]};
      F3_H:    loadData_o = {{16{lane[15]}}, lane[15:0]};
      F3_HU:   loadData_o = {16'b0, lane[15:0]};
      default: loadData_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one data-memory transaction at a time
// with a ready handshake and optional timeout, stalls the front of the pipe
// while it waits, and registers the MEM/WB bundle for writeback/forwarding.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic [1:0]  ex_wb_sel,
  input  logic [31:0] ex_pc,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_alu,
  output logic        stall_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  output logic        wb_valid,
  output logic [31:0] wb_dmem,
  output logic [31:0] wb_alu,
  output logic [31:0] wb_pc,
  output logic [1:0]  wb_sel,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        misalign_exc,
  output logic        bus_err
);

  lsu_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        dmemReq_q, dmemReq_d, dmemWe_q, dmemWe_d;
  logic [31:0] dmemAddr_q, dmemAddr_d, dmemWdata_q, dmemWdata_d;
  logic [3:0]  dmemWstrb_q, dmemWstrb_d;

  logic [31:0] capAlu_q, capAlu_d, capPc_q, capPc_d;
  logic [2:0]  capFunct3_q, capFunct3_d;
  logic [4:0]  capRd_q, capRd_d;
  logic [1:0]  capSel_q, capSel_d;
  logic        capRegWrite_q, capRegWrite_d, capStore_q, capStore_d;

  logic        wbValid_q, wbValid_d, wbRegWrite_q, wbRegWrite_d;
  logic [31:0] wbDmem_q, wbDmem_d, wbAlu_q, wbAlu_d, wbPc_q, wbPc_d;
  logic [1:0]  wbSel_q, wbSel_d;
  logic [4:0]  wbRd_q, wbRd_d;
  logic        misalign_q, misalign_d, busErr_q, busErr_d;

  logic        memOp, misaligned, startReq, timeoutHit, finishReq;
  logic [31:0] loadData;

  lsu_load_format u_format (
    .rdata_i    (dmem_rdata),
    .addrLo_i   (capAlu_q[1:0]),
    .funct3_i   (capFunct3_q),
    .loadData_o (loadData)
  );

  // Classify the incoming EX/MEM op and detect the end of an outstanding request.
  always_comb begin
    memOp      = ex_valid && (ex_mem_read || ex_mem_write);
    misaligned = memOp && isMisaligned(ex_funct3, ex_alu_result[1:0]);
    startReq   = (state_q == IDLE) && memOp && !misaligned;
    timeoutHit = (BUS_TIMEOUT != 0) && (cnt_q == CNT_W'(BUS_TIMEOUT - 1));
    finishReq  = (state_q == BUSY) && (dmem_ready || timeoutHit);
  end

  // State register; a synchronous reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Enter BUSY when an aligned access is launched, leave on ready or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (startReq)  state_d = BUSY;
      BUSY:    if (finishReq) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stall request plus next values of the bus request and MEM/WB bundle.
  always_comb begin
    stall_req     = 1'b0;
    cnt_d         = cnt_q;
    dmemReq_d     = dmemReq_q;
    dmemWe_d      = dmemWe_q;
    dmemAddr_d    = dmemAddr_q;
    dmemWdata_d   = dmemWdata_q;
    dmemWstrb_d   = dmemWstrb_q;
    capAlu_d      = capAlu_q;
    capPc_d       = capPc_q;
    capFunct3_d   = capFunct3_q;
    capRd_d       = capRd_q;
    capSel_d      = capSel_q;
    capRegWrite_d = capRegWrite_q;
    capStore_d    = capStore_q;
    wbValid_d     = 1'b0;
    wbRegWrite_d  = 1'b0;
    wbDmem_d      = wbDmem_q;
    wbAlu_d       = wbAlu_q;
    wbPc_d        = wbPc_q;
    wbSel_d       = wbSel_q;
    wbRd_d        = wbRd_q;
    misalign_d    = 1'b0;
    busErr_d      = 1'b0;
    case (state_q)
      IDLE: begin
        stall_req = startReq;
        if (startReq) begin
          cnt_d         = '0;
          capAlu_d      = ex_alu_result;
          capPc_d       = ex_pc;
          capFunct3_d   = ex_funct3;
          capRd_d       = ex_rd;
          capSel_d      = ex_wb_sel;
          capRegWrite_d = ex_reg_write;
          capStore_d    = ex_mem_write;
          dmemReq_d     = 1'b1;
          dmemWe_d      = ex_mem_write;
          dmemAddr_d    = {ex_alu_result[31:2], 2'b00};
          dmemWdata_d   = '0;
          dmemWstrb_d   = '0;
          if (ex_mem_write) begin
            case (ex_funct3)
              F3_B: begin
                dmemWdata_d = {4{ex_store_data[7:0]}};
                dmemWstrb_d = 4'b0001 << ex_alu_result[1:0];
              end
              F3_H: begin
                dmemWdata_d = {2{ex_store_data[15:0]}};
                dmemWstrb_d = 4'b0011 << ex_alu_result[1:0];
              end
              default: begin
                dmemWdata_d = ex_store_data;
                dmemWstrb_d = 4'b1111;
              end
            endcase
          end
        end else if (ex_valid) begin
          wbValid_d    = 1'b1;
          wbDmem_d     = '0;
          wbAlu_d      = ex_alu_result;
          wbPc_d       = ex_pc;
          wbSel_d      = ex_wb_sel;
          wbRd_d       = ex_rd;
          wbRegWrite_d = ex_reg_write && !misaligned;
          misalign_d   = misaligned;
        end
      end
      BUSY: begin
        stall_req = !dmem_ready && !timeoutHit;
        cnt_d     = cnt_q + 1'b1;
        if (finishReq) begin
          dmemReq_d = 1'b0;
          dmemWe_d  = 1'b0;
          wbValid_d = 1'b1;
          wbAlu_d   = capAlu_q;
          wbPc_d    = capPc_q;
          wbSel_d   = capSel_q;
          wbRd_d    = capRd_q;
          if (dmem_ready) begin
            wbDmem_d     = capStore_q ? 32'b0 : loadData;
            wbRegWrite_d = capRegWrite_q && !capStore_q;
          end else begin
            wbDmem_d = '0;
            busErr_d = 1'b1;
          end
        end
      end
      default: stall_req = 1'b0;
    endcase
  end

  // Registered request, captured instruction fields and MEM/WB bundle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      dmemReq_q     <= 1'b0;
      dmemWe_q      <= 1'b0;
      dmemAddr_q    <= '0;
      dmemWdata_q   <= '0;
      dmemWstrb_q   <= '0;
      capAlu_q      <= '0;
      capPc_q       <= '0;
      capFunct3_q   <= '0;
      capRd_q       <= '0;
      capSel_q      <= '0;
      capRegWrite_q <= 1'b0;
      capStore_q    <= 1'b0;
      wbValid_q     <= 1'b0;
      wbRegWrite_q  <= 1'b0;
      wbDmem_q      <= '0;
      wbAlu_q       <= '0;
      wbPc_q        <= '0;
      wbSel_q       <= '0;
      wbRd_q        <= '0;
      misalign_q    <= 1'b0;
      busErr_q      <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      dmemReq_q     <= dmemReq_d;
      dmemWe_q      <= dmemWe_d;
      dmemAddr_q    <= dmemAddr_d;
      dmemWdata_q   <= dmemWdata_d;
      dmemWstrb_q   <= dmemWstrb_d;
      capAlu_q      <= capAlu_d;
      capPc_q       <= capPc_d;
      capFunct3_q   <= capFunct3_d;
      capRd_q       <= capRd_d;
      capSel_q      <= capSel_d;
      capRegWrite_q <= capRegWrite_d;
      capStore_q    <= capStore_d;
      wbValid_q     <= wbValid_d;
      wbRegWrite_q  <= wbRegWrite_d;
      wbDmem_q      <= wbDmem_d;
      wbAlu_q       <= wbAlu_d;
      wbPc_q        <= wbPc_d;
      wbSel_q       <= wbSel_d;
      wbRd_q        <= wbRd_d;
      misalign_q    <= misalign_d;
      busErr_q      <= busErr_d;
    end
  end

  assign mem_alu      = ex_alu_result;
  assign dmem_req     = dmemReq_q;
  assign dmem_we      = dmemWe_q;
  assign dmem_addr    = dmemAddr_q;
  assign dmem_wdata   = dmemWdata_q;
  assign dmem_wstrb   = dmemWstrb_q;
  assign wb_valid     = wbValid_q;
  assign wb_dmem      = wbDmem_q;
  assign wb_alu       = wbAlu_q;
  assign wb_pc        = wbPc_q;
  assign wb_sel       = wbSel_q;
  assign wb_rd        = wbRd_q;
  assign wb_reg_write = wbRegWrite_q;
  assign misalign_exc = misalign_q;
  assign bus_err      = busErr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomised scoreboard bench for mem_stage_lsu: a pipeline-style driver,
// a delay-programmable memory responder and a writeback monitor.
module tb_mem_stage_lsu;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [31:0] ex_alu_result, ex_store_data, ex_pc;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_wb_sel;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_alu, dmem_addr, dmem_wdata, wb_dmem, wb_alu, wb_pc;
  logic        stall_req, dmem_req, dmem_we, wb_valid, wb_reg_write, misalign_exc, bus_err;
  logic [3:0]  dmem_wstrb;
  logic [1:0]  wb_sel;
  logic [4:0]  wb_rd;

  typedef struct {
    bit          valid;
    bit          isLoad;
    bit          isStore;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    bit          regw;
    logic [1:0]  sel;
    logic [31:0] pc;
    int          delay;
    logic [31:0] rdata;
  } opT;

  typedef struct {
    logic [31:0] alu, pc, dmem;
    logic [1:0]  sel;
    logic [4:0]  rd;
    bit          regw, mis, err, chkDmem;
  } wbExpT;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wstrb;
    bit          we;
    int          delay;
  } reqExpT;

  wbExpT  wbQ[$];
  reqExpT reqQ[$];
  int     errors = 0;
  int     checks = 0;
  bit     lastValid = 0;

  mem_stage_lsu #(.BUS_TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_wb_sel(ex_wb_sel),
    .ex_pc(ex_pc), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .mem_alu(mem_alu),
    .stall_req(stall_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .wb_valid(wb_valid), .wb_dmem(wb_dmem),
    .wb_alu(wb_alu), .wb_pc(wb_pc), .wb_sel(wb_sel), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .misalign_exc(misalign_exc), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int accessSize(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic opT mkOp(input bit valid, input bit ld, input bit st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                              input bit regw, input logic [1:0] sel, input logic [31:0] pc,
                              input int delay, input logic [31:0] rdata);
    opT o;
    o.valid = valid; o.isLoad = ld; o.isStore = st; o.f3 = f3; o.addr = addr; o.sdata = sdata;
    o.rd = rd; o.regw = regw; o.sel = sel; o.pc = pc; o.delay = delay; o.rdata = rdata;
    return o;
  endfunction

  // Build the expected request and writeback from the access rules, then
  // present the op and hold it while the DUT stalls, as the pipeline would.
  task automatic applyStimulus(input opT op);
    wbExpT  w;
    reqExpT r;
    int     size, off, expStall, stallCnt;
    bit     memOp, mis, timedOut, sampledStall, accepted;
    longint val;
    memOp    = op.valid && (op.isLoad || op.isStore);
    size     = accessSize(op.f3);
    off      = int'(op.addr[1:0]);
    mis      = memOp && ((off % size) != 0);
    expStall = 0;
    if (op.valid) begin
      w.alu = op.addr; w.pc = op.pc; w.sel = op.sel; w.rd = op.rd;
      w.mis = mis; w.err = 0; w.chkDmem = 0; w.dmem = 0; w.regw = 0;
      if (!memOp) begin
        w.regw = op.regw; w.chkDmem = 1;
      end else if (!mis) begin
        timedOut = (op.delay >= TIMEOUT);
        expStall = 1 + (timedOut ? TIMEOUT - 1 : op.delay);
        r.addr = op.addr & ~32'd3; r.we = op.isStore; r.delay = op.delay; r.rdata = op.rdata;
        r.wstrb = 4'b0; r.wdata = 32'b0;
        if (op.isStore) begin
          r.wstrb = 4'(((1 << size) - 1) << off);
          if (size == 1)      r.wdata = (op.sdata & 32'hFF) * 32'h0101_0101;
          else if (size == 2) r.wdata = (op.sdata & 32'hFFFF) * 32'h0001_0001;
          else                r.wdata = op.sdata;
        end
        reqQ.push_back(r);
        if (timedOut) w.err = 1;
        else if (op.isLoad) begin
          w.regw = op.regw; w.chkDmem = 1;
          val = longint'(op.rdata >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
          if (!op.f3[2] && val >= (64'd1 << (8 * size - 1))) val = val - (64'd1 << (8 * size));
          w.dmem = 32'(val);
        end
      end
      wbQ.push_back(w);
    end
    ex_valid = op.valid; ex_alu_result = op.addr; ex_store_data = op.sdata;
    ex_mem_read = op.isLoad; ex_mem_write = op.isStore; ex_funct3 = op.f3;
    ex_rd = op.rd; ex_reg_write = op.regw; ex_wb_sel = op.sel; ex_pc = op.pc;
    stallCnt = 0;
    accepted = 0;
    for (int c = 0; c < 40 && !accepted; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checkOutput("mem_alu", mem_alu, op.addr);
        checkOutput("req_idle", {31'b0, dmem_req}, 32'd0);
        checkOutput("wb_valid_timing", {31'b0, wb_valid}, {31'b0, lastValid});
      end
      sampledStall = stall_req;
      if (sampledStall) stallCnt++;
      @(posedge clk);
      #1;
      if (!sampledStall) accepted = 1;
    end
    if (!accepted) begin
      checks++; errors++;
      $display("[TB] FAIL accept_bound: op at 0x%08h still stalled after 40 cycles", op.addr);
    end
    checkOutput("stall_cycles", stallCnt, expStall);
    lastValid = op.valid;
  endtask

  reqExpT cur;
  bit     active = 0;
  int     waitLeft = 0;

  // Memory responder: checks each new request, then answers after its programmed wait.
  always @(posedge clk) begin
    #1;
    if (dmem_req) begin
      if (!active) begin
        active = 1;
        if (reqQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_req: dmem_req=1 at addr 0x%08h, expected no request", dmem_addr);
          cur.addr = dmem_addr; cur.we = dmem_we; cur.wdata = dmem_wdata; cur.wstrb = dmem_wstrb;
          cur.delay = 1000; cur.rdata = 32'b0;
        end else begin
          cur = reqQ.pop_front();
          checkOutput("req_addr", dmem_addr, cur.addr);
          checkOutput("req_we", {31'b0, dmem_we}, {31'b0, cur.we});
          if (cur.we) begin
            checkOutput("req_wdata", dmem_wdata, cur.wdata);
            checkOutput("req_wstrb", {28'b0, dmem_wstrb}, {28'b0, cur.wstrb});
          end
        end
        waitLeft = cur.delay;
      end else begin
        checkOutput("req_stable_addr", dmem_addr, cur.addr);
        checkOutput("req_stable_we", {31'b0, dmem_we}, {31'b0, cur.we});
      end
      if (waitLeft == 0) begin
        dmem_ready = 1'b1; dmem_rdata = cur.rdata;
      end else begin
        dmem_ready = 1'b0; dmem_rdata = $urandom; waitLeft--;
      end
    end else begin
      active = 0; dmem_ready = 1'b0;
    end
  end

  wbExpT mw;

  // Writeback monitor: every wb_valid pulse must match the oldest expected bundle.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (wbQ.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_wb: wb_valid=1 with wb_alu 0x%08h, expected no writeback", wb_alu);
      end else begin
        mw = wbQ.pop_front();
        checkOutput("wb_alu", wb_alu, mw.alu);
        checkOutput("wb_pc", wb_pc, mw.pc);
        checkOutput("wb_sel", {30'b0, wb_sel}, {30'b0, mw.sel});
        checkOutput("wb_rd", {27'b0, wb_rd}, {27'b0, mw.rd});
        checkOutput("wb_reg_write", {31'b0, wb_reg_write}, {31'b0, mw.regw});
        checkOutput("misalign_exc", {31'b0, misalign_exc}, {31'b0, mw.mis});
        checkOutput("bus_err", {31'b0, bus_err}, {31'b0, mw.err});
        if (mw.chkDmem) checkOutput("wb_dmem", wb_dmem, mw.dmem);
      end
    end else begin
      checkOutput("pulse_without_wb", {30'b0, misalign_exc, bus_err}, 32'd0);
    end
  end

  logic [2:0]  loadF3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  opT          rop;
  reqExpT      rr;
  int          kind;
  logic [31:0] a;

  initial begin
    ex_valid = 0; ex_alu_result = 0; ex_store_data = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_funct3 = 0; ex_rd = 0; ex_reg_write = 0; ex_wb_sel = 0; ex_pc = 0;
    dmem_ready = 0; dmem_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    checkOutput("rst_dmem_we", {31'b0, dmem_we}, 32'd0);
    checkOutput("rst_dmem_addr", dmem_addr, 32'd0);
    checkOutput("rst_dmem_wdata", dmem_wdata, 32'd0);
    checkOutput("rst_dmem_wstrb", {28'b0, dmem_wstrb}, 32'd0);
    checkOutput("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    checkOutput("rst_wb_dmem", wb_dmem, 32'd0);
    checkOutput("rst_wb_alu", wb_alu, 32'd0);
    checkOutput("rst_wb_pc", wb_pc, 32'd0);
    checkOutput("rst_wb_rd_sel", {25'b0, wb_rd, wb_sel}, 32'd0);
    checkOutput("rst_wb_reg_write", {31'b0, wb_reg_write}, 32'd0);
    checkOutput("rst_exc", {30'b0, misalign_exc, bus_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] directed accesses");
    applyStimulus(mkOp(1, 1, 0, 3'b010, 32'h100, 32'h0, 5'd3, 1, 2'b00, 32'h1000, 0, 32'hDEADBEEF));
    applyStimulus(mkOp(1, 1, 0, 3'b000, 32'h103, 32'h0, 5'd4, 1, 2'b00, 32'h1004, 1, 32'h80112233));
    applyStimulus(mkOp(1, 1, 0, 3'b100, 32'h103, 32'h0, 5'd5, 1, 2'b00, 32'h1008, 0, 32'h80112233));
    applyStimulus(mkOp(1, 0, 1, 3'b001, 32'h202, 32'h0000ABCD, 5'd0, 0, 2'b00, 32'h100C, 2, 32'h0));
    applyStimulus(mkOp(1, 1, 0, 3'b010, 32'h101, 32'h0, 5'd6, 1, 2'b00, 32'h1010, 0, 32'h0));
    applyStimulus(mkOp(1, 0, 0, 3'b000, 32'h1234, 32'h0, 5'd7, 1, 2'b01, 32'h1014, 0, 32'h0));
    applyStimulus(mkOp(1, 1, 0, 3'b010, 32'h400, 32'h0, 5'd8, 1, 2'b00, 32'h1018, 100, 32'h0));
    applyStimulus(mkOp(1, 1, 0, 3'b101, 32'h402, 32'h0, 5'd9, 1, 2'b00, 32'h101C, 3, 32'hF00D8001));
    applyStimulus(mkOp(1, 0, 1, 3'b000, 32'h3, 32'h123456A5, 5'd0, 1, 2'b00, 32'h1020, 0, 32'h0));
    applyStimulus(mkOp(0, 1, 0, 3'b010, 32'h500, 32'h0, 5'd1, 1, 2'b00, 32'h1024, 0, 32'h0));

    $display("[TB] reset during a pending load");
    rr.addr = 32'h300; rr.we = 0; rr.wdata = 0; rr.wstrb = 0; rr.delay = 3; rr.rdata = 32'h12345678;
    reqQ.push_back(rr);
    ex_valid = 1; ex_alu_result = 32'h300; ex_mem_read = 1; ex_mem_write = 0;
    ex_funct3 = 3'b010; ex_rd = 5'd10; ex_reg_write = 1; ex_wb_sel = 2'b00; ex_pc = 32'h2000;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("busy_req", {31'b0, dmem_req}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; ex_valid = 0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mid_req", {31'b0, dmem_req}, 32'd0);
    checkOutput("rst_mid_wb_valid", {31'b0, wb_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    lastValid = 0;
    applyStimulus(mkOp(1, 0, 0, 3'b000, 32'h0BADF00D, 32'h0, 5'd11, 1, 2'b01, 32'h2004, 0, 32'h0));

    $display("[TB] randomised traffic");
    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 9);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      rop = mkOp(1, 0, 0, 3'($urandom), a, $urandom, 5'($urandom), 1'($urandom), 2'($urandom_range(0, 2)),
                 $urandom, $urandom_range(0, 5), $urandom);
      if (kind == 0) rop.valid = 0;
      else if (kind >= 4 && kind <= 6) begin
        rop.isLoad = 1; rop.f3 = loadF3[$urandom_range(0, 4)];
      end else if (kind >= 7) begin
        rop.isStore = 1; rop.f3 = 3'($urandom_range(0, 2));
      end
      applyStimulus(rop);
    end

    ex_valid = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("wb_queue_drained", wbQ.size(), 32'd0);
    checkOutput("req_queue_drained", reqQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- MEM-stage load/store unit of the 5-stage RV32I pipeline, directly downstream of the EX-stage ALU.
- Consumes the EX/MEM-registered ALU result as the address and rs2 as store data.
- Runs a ready-handshake transaction to data memory, aligns and extends load data, and registers the MEM/WB bundle.
- That bundle feeds writeback and the ALU forwarding inputs (WBdmem, WBAlu, WBPC, WBSel, MEMAlu).

Parameters:
- BUS_TIMEOUT, 255: max cycles dmem_req may wait for dmem_ready before abort. 0 disables the timeout.
- CNT_W, 8: timeout counter width. Must hold BUS_TIMEOUT.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous reset, active-low.
- ex_valid  in  1  EX/MEM register holds a live instruction.
- ex_alu_result  in  32  ALU result; the address for loads/stores.
- ex_store_data  in  32  forwarded rs2 value.
- ex_mem_read  in  1  instruction is a load.
- ex_mem_write  in  1  instruction is a store.
- ex_funct3  in  3  access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  instruction writes rd.
- ex_wb_sel  in  2  00 dmem, 01 alu, 10 pc+4.
- ex_pc  in  32  instruction PC.
- dmem_ready  in  1  memory completes the current request this cycle.
- dmem_rdata  in  32  read word; valid when dmem_ready.
- mem_alu  out  32  combinational copy of ex_alu_result (MEMAlu forward path).
- stall_req  out  1  hold PC/IF/ID/EX and the EX/MEM register.
- dmem_req  out  1  request valid.
- dmem_we  out  1  write request.
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_wstrb  out  4  byte enables.
- wb_valid  out  1  MEM/WB bundle valid.
- wb_dmem  out  32  formatted load data.
- wb_alu  out  32  ALU result.
- wb_pc  out  32  instruction PC (the +4 is applied downstream).
- wb_sel  out  2  writeback select.
- wb_rd  out  5  destination register.
- wb_reg_write  out  1  final write enable.
- misalign_exc  out  1  one-cycle pulse with wb_valid for a misaligned access.
- bus_err  out  1  one-cycle pulse with wb_valid for a timed-out access.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. All registered outputs 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, all wb_*, misalign_exc, bus_err, timeout counter.
- Reset mid-transaction: dmem_req drops on the same edge. No writeback is produced.
- States are IDLE and BUSY.
- IDLE, non-memory op (ex_valid, no read/write):
  - Next edge: wb_valid=1, wb_* copied from ex_*, wb_dmem=0.
  - stall_req=0. Latency 1.
- IDLE, ex_valid=0: next edge wb_valid=0 and wb_reg_write=0.
- Misalignment rule:
  - H/HU/SH with addr[0]=1 is misaligned.
  - W/SW with addr[1:0]!=0 is misaligned.
- IDLE, misaligned memory op:
  - No bus request. stall_req=0.
  - Next edge: wb_valid=1, wb_reg_write=0, misalign_exc=1.
- IDLE, aligned memory op:
  - stall_req=1 combinationally.
  - Next edge captures addr, funct3, rd, wb_sel, pc, reg_write. Sets dmem_req=1, dmem_we=ex_mem_write, and the store wdata/wstrb. Enters BUSY.
  - Store encoding:
    - SB: wdata={4{b}}, wstrb=0001<<addr[1:0].
    - SH: wdata={2{h}}, wstrb=0011<<addr[1:0].
    - SW: wstrb=1111.
- BUSY, inputs: ex_* inputs are ignored.
- BUSY, stall_req: stall_req=!dmem_ready && !timeout_hit.
- BUSY, dmem_ready:
  - Next edge: dmem_req=0, state IDLE, wb_valid=1.
  - Load: wb_dmem = byte/half lane selected by addr[1:0], sign- or zero-extended per funct3. wb_reg_write=captured value.
  - Store: wb_reg_write=0.
- BUSY, request and counter:
  - dmem_req and all request fields stay stable until dmem_ready.
  - The counter increments each BUSY cycle.
- BUSY, timeout (counter==BUS_TIMEOUT-1 without ready, BUS_TIMEOUT!=0):
  - Next edge: dmem_req=0, IDLE, wb_valid=1, wb_reg_write=0, bus_err=1.
- BUSY, ready and timeout in the same cycle: ready wins; no bus_err.
- Zero-wait memory: a load costs exactly one stall cycle. wb_valid asserts 2 edges after the EX/MEM register presents the op.
- Back-to-back memory ops:
  - The second op is sampled in the IDLE cycle that follows the completion edge.
  - At most one transaction is outstanding.
- wb_pc is registered unmodified.
- mem_alu is purely combinational.

Decomposition:
- Shared package mem_pkg:
  - funct3 load/store encodings.
  - WB_SEL_DMEM=2'b00, WB_SEL_ALU=2'b01, WB_SEL_PC4=2'b10.
  - lsu_state_t {IDLE, BUSY}.
- Sub-module lsu_load_format, combinational:
  - Inputs: rdata, addr[1:0], funct3.
  - Output: 32-bit extended load value.
  - Reused by the verification model.

Test Plan:
- LW at 0x100, dmem_ready one cycle after dmem_req, rdata=0xDEADBEEF -> one stall cycle; dmem_addr=0x100; wb_dmem=0xDEADBEEF, wb_reg_write=1, wb_sel=00.
- LB at 0x103 and LBU at 0x103, rdata=0x80112233 -> LB wb_dmem=0xFFFFFF80; LBU wb_dmem=0x00000080.
- SH at 0x202, data=0x0000ABCD -> dmem_we=1, dmem_addr=0x200, wstrb=1100, wdata=0xABCDABCD; wb_reg_write=0.
- LW at 0x101 -> no dmem_req; next edge misalign_exc=1, wb_valid=1, wb_reg_write=0; stall_req never high.
- BUS_TIMEOUT=4 with dmem_ready held 0 -> stall_req high 4 cycles; then dmem_req=0, bus_err=1, wb_reg_write=0.
- Load with dmem_ready after 3 wait cycles, rst_n=0 on the 2nd wait cycle -> next edge dmem_req=0, wb_valid=0, state IDLE; an ADD presented after reset gives wb_valid=1, wb_alu=ex_alu_result.
